// File: rtl/multu_seq.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier, one partial-product step per clock.
// Latency: 1 load + WIDTH MULTU cycles, then one OUT cycle publishes {HI, LO} on dataOut.
// No backpressure: the caller sequences Signal and waits for done before issuing OUT.
module multu_seq #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  OUT   = 6'b111111
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    input  logic [5:0]           Signal,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 done
);

    localparam logic [5:0] LAST = 6'(WIDTH);

    logic [WIDTH-1:0]   mcnd;
    logic [2*WIDTH-1:0] prod;
    logic               c;
    logic [5:0]         count;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    // c is always zero after a shift, so folding it into the adder keeps the sum exact.
    always_comb begin
        sum     = '0;
        shifted = '0;
        sum     = {c, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcnd} : '0);
        shifted = {sum, prod[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcnd    <= '0;
            prod    <= '0;
            c       <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
            dataOut <= '0;
        end else if (Signal == MULTU) begin
            if (count < LAST) begin
                {c, prod} <= shifted;
                count     <= count + 6'd1;
                done      <= (count + 6'd1 == LAST);
            end
        end else if (Signal == OUT) begin
            dataOut <= prod;
        end else begin
            mcnd  <= dataA;
            prod  <= {{WIDTH{1'b0}}, dataB};
            c     <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq: an arithmetic reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_multu_seq;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] OUT   = 6'b111111;
    localparam logic [5:0] LOAD  = 6'b000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA, dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    multu_seq dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference: operands, steps taken, and the published value.
    logic [31:0] ma, mb;
    int          mk;
    logic        mdone;
    logic [63:0] mout;

    // Register contents after k steps: low k multiplier bits times a, aligned to the top,
    // with the not-yet-consumed multiplier bits below.
    function automatic logic [63:0] partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] mask;
        logic [63:0] pp;
        mask = (k >= 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << k) - 64'd1);
        pp   = {32'b0, a} * ({32'b0, b} & mask);
        return (pp << (32 - k)) | ({32'b0, b} >> k);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            ma = '0; mb = '0; mk = 0; mdone = 1'b0; mout = '0;
        end else if (Signal == MULTU) begin
            if (mk < 32) mk = mk + 1;
            mdone = (mk == 32);
        end else if (Signal == OUT) begin
            mout = partial(ma, mb, mk);
        end else begin
            ma = dataA; mb = dataB; mk = 0; mdone = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_done", {63'b0, done}, {63'b0, mdone});
            check("model_dataOut", dataOut, mout);
        end
    end

    task automatic step(input logic [5:0] sig);
        Signal = sig;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        dataA = a;
        dataB = b;
        step(LOAD);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(MULTU);
    endtask

    initial begin
        reset  = 1'b0;
        Signal = LOAD;
        dataA  = '0;
        dataB  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_dataOut", dataOut, 64'h0);
        check("reset_done", {63'b0, done}, 64'h0);
        cmp_en = 1'b1;
        reset  = 1'b1;

        // 7 * 6
        load(32'd7, 32'd6);
        run(31);
        check("t1_done_before_last", {63'b0, done}, 64'h0);
        run(1);
        check("t1_done", {63'b0, done}, 64'h1);
        step(OUT);
        check("t1_prod", dataOut, 64'h0000_0000_0000_002A);

        // Full-scale operands exercise the carry out of the adder.
        load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(32);
        step(OUT);
        check("t2_prod", dataOut, 64'hFFFF_FFFE_0000_0001);

        load(32'h0, 32'h1234_5678);
        run(32);
        step(OUT);
        check("t3_zero", dataOut, 64'h0);
        load(32'h8000_0000, 32'd2);
        run(32);
        step(OUT);
        check("t3_msb", dataOut, 64'h0000_0001_0000_0000);

        // Reset mid-operation abandons the run and clears dataOut.
        load(32'd3, 32'd5);
        run(10);
        reset = 1'b0;
        step(LOAD);
        reset = 1'b1;
        check("t4_reset_dataOut", dataOut, 64'h0);
        check("t4_reset_done", {63'b0, done}, 64'h0);
        load(32'd9, 32'd9);
        run(32);
        step(OUT);
        check("t4_prod", dataOut, 64'd81);

        // Surplus MULTU cycles hold the result; load leaves dataOut alone.
        load(32'd100, 32'd200);
        check("t5_load_keeps_out", dataOut, 64'd81);
        run(40);
        check("t5_done_held", {63'b0, done}, 64'h1);
        step(OUT);
        check("t5_prod", dataOut, 64'd20000);

        // Reload mid-run restarts; an early OUT publishes the partial register.
        load(32'd11, 32'd13);
        run(5);
        step(OUT);
        check("t6_partial", dataOut, 64'h0000_0004_7800_0000);
        load(32'd2, 32'd3);
        check("t6_done_cleared", {63'b0, done}, 64'h0);
        run(31);
        check("t6_done_before_last", {63'b0, done}, 64'h0);
        run(1);
        check("t6_done", {63'b0, done}, 64'h1);
        step(OUT);
        check("t6_prod", dataOut, 64'd6);

        step(LOAD);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
